// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmit and receive paths:
// FSM state encodings, frame length, default timing constants and the
// odd-parity helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // Defaults assume a 100 MHz system clock.
  localparam int INHIBIT_CYCLES_DEF = 12000;    // 120 us
  localparam int REQ_CYCLES_DEF     = 200;      // 2 us
  localparam int TIMEOUT_CYCLES_DEF = 2000000;  // 20 ms
  localparam int FILTER_LEN_DEF     = 8;

  // Extra attempts after the first one when retries are built in.
  localparam int MAX_RETRIES = 2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Input conditioning for the PS/2 lines, shared by host TX and RX paths.
// Both lines get a 2-FF synchronizer; the clock additionally gets a
// FILTER_LEN-sample debounce and a one-cycle falling-edge pulse.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   ps2_clk_i   in   raw PS/2 clock line level
//   ps2_data_i  in   raw PS/2 data line level
//   clk_filt_o  out  debounced clock level
//   data_sync_o out  synchronized data level
//   clk_fall_o  out  one-cycle pulse on filtered clock 1->0
// ---------------------------------------------------------------------------
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_filt_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle bus level is high; resetting to 1 avoids a spurious fall.
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      fall_q      <= 1'b0;
      // cnt_q counts consecutive samples that disagree with the filtered
      // level; any agreeing sample restarts the run.
      if (clk_sync_q[1] == clk_filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        cnt_q      <= '0;
        fall_q     <= clk_filt_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign clk_filt_o  = clk_filt_q;
  assign data_sync_o = data_sync_q[1];
  assign clk_fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte per request:
// inhibits the clock, issues the request-to-send, shifts start/D0..D7/
// odd parity/stop on device clock falls, then samples the device ACK.
// Outputs are open-collector enables only; the tristates live above.
//
// Build option: define PS2_TX_RETRY_EN to retry a NACK or timeout up to
// MAX_RETRIES times with the same byte before reporting.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   synchronous active-high reset
//   ps2_clk_in   in   raw PS/2 clock line level
//   ps2_data_in  in   raw PS/2 data line level
//   tx_data      in   command byte, latched on accept
//   tx_valid     in   request strobe
//   tx_ready     out  idle, can accept a byte
//   tx_busy      out  transmission in progress
//   ps2_clk_oe   out  1 = pull ps2_clk low
//   ps2_data_oe  out  1 = pull ps2_data low
//   tx_done      out  one-cycle completion pulse
//   tx_err       out  qualifies tx_done: 1 = NACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int REQ_CYCLES     = REQ_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_filt;
  logic data_sync;
  logic clk_fall;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .clk_filt_o (clk_filt),
    .data_sync_o(data_sync),
    .clk_fall_o (clk_fall)
  );

  ps2_state_e       state_q;
  logic [7:0]       byte_q;
  logic [3:0]       bit_idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [WD_W-1:0]  wdog_q;
  logic             nack_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q;
`endif

  logic [FRAME_LEN-1:0] frame_w;
  logic                 in_frame_w;
  logic                 timeout_w;
  logic                 idle_seen_w;
  logic                 attempt_end_w;
  logic                 attempt_fail_w;
  logic                 retry_w;

  always_comb begin
    // Bit 0 is the start bit, already on the line from REQ; fall k drives bit k.
    frame_w        = {1'b1, odd_parity(byte_q), byte_q, 1'b0};
    in_frame_w     = (state_q == ST_SEND) || (state_q == ST_ACK) ||
                     (state_q == ST_WAIT_IDLE);
    timeout_w      = in_frame_w && (wdog_q == '0);
    idle_seen_w    = (state_q == ST_WAIT_IDLE) && clk_filt && data_sync;
    attempt_end_w  = timeout_w || idle_seen_w;
    attempt_fail_w = timeout_w || nack_q;
`ifdef PS2_TX_RETRY_EN
    retry_w        = attempt_fail_w && (retry_q < 2'(MAX_RETRIES));
`else
    retry_w        = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      bit_idx_q <= '0;
      timer_q   <= '0;
      wdog_q    <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // Watchdog spans the whole frame from clock release; never per bit.
      if (in_frame_w && (wdog_q != '0)) begin
        wdog_q <= wdog_q - 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            byte_q   <= tx_data;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            timer_q  <= TMR_W'(INHIBIT_CYCLES - 1);
            state_q  <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_q  <= '0;
`endif
          end
        end

        ST_INHIBIT: begin
          if (timer_q == '0) begin
            data_oe_q <= 1'b1;
            timer_q   <= TMR_W'(REQ_CYCLES - 1);
            state_q   <= ST_REQ;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        ST_REQ: begin
          if (timer_q == '0) begin
            clk_oe_q  <= 1'b0;
            bit_idx_q <= '0;
            wdog_q    <= WD_W'(TIMEOUT_CYCLES - 1);
            state_q   <= ST_SEND;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        ST_SEND: begin
          if (clk_fall) begin
            data_oe_q <= ~frame_w[bit_idx_q + 4'd1];
            bit_idx_q <= bit_idx_q + 4'd1;
            // The fall that releases the stop bit ends the shift phase.
            if (bit_idx_q == 4'(FRAME_LEN - 2)) begin
              state_q <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          if (clk_fall) begin
            nack_q  <= data_sync;
            state_q <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // End of an attempt overrides anything the case above decided.
      if (attempt_end_w) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        bit_idx_q <= '0;
        wdog_q    <= '0;
        if (retry_w) begin
          clk_oe_q <= 1'b1;
          timer_q  <= TMR_W'(INHIBIT_CYCLES - 1);
          state_q  <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_q  <= retry_q + 2'd1;
`endif
        end else begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= attempt_fail_w;
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx (default build, no retries). A
// behavioural PS/2 device clocks the frame, samples bits on its rising
// edges and optionally ACKs. Timing parameters are shortened so the
// whole run stays short.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH = 120;
  localparam int RQ  = 20;
  localparam int TMO = 3000;
  localparam int H   = 40;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (RQ),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   inh_cnt  = 0;
  int   req_cnt  = 0;
  logic done_err, done_clk_oe, done_data_oe, done_ready;
  logic prev_data_oe = 1'b0;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      done_err     = tx_err;
      done_clk_oe  = ps2_clk_oe;
      done_data_oe = ps2_data_oe;
      done_ready   = tx_ready;
    end
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
    if (ps2_clk_oe && ps2_data_oe && !prev_data_oe) req_cnt++;
    prev_data_oe = ps2_data_oe;
  end

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         glitch_bit;
    logic [9:0] exp_frame;   // {stop, parity, D7..D0} as sampled by device
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  logic [9:0] cap;
  logic       seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("ready_drop", tx_ready, 1'b0);
    chk("busy_rise", tx_busy, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3 * TMO) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt >= target, 1'b1);
  endtask

  // Device side of a host-to-device frame. abort_at >= 0 stops clocking
  // before that fall; glitch_bit >= 0 injects a 3-cycle low pulse in the
  // high phase after that bit.
  task automatic dev_receive(input logic ack, input int glitch_bit, input int abort_at,
                             output logic [9:0] bits, output logic found);
    int n = 0;
    bits  = '0;
    found = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < INH + RQ + 50);
    if (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)) return;
    found = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) return;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = ps2_data_line;
      if (i == glitch_bit) begin
        repeat (12) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H - 15) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    if (ack) dev_data = 1'b0;
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int d0 = done_cnt;
    int i0 = inh_cnt;
    send_byte(v.data);
    dev_receive(v.ack, v.glitch_bit, -1, cap, seen);
    chk("start_seen", seen, 1'b1);
    chk("frame_bits", cap, v.exp_frame);
    wait_done(d0 + 1);
    chk("done_err", done_err, v.exp_err);
    chk("lines_released", {done_clk_oe, done_data_oe}, 2'b00);
    chk("ready_at_done", done_ready, 1'b1);
    chk("inhibit_len", inh_cnt - i0, INH);
    repeat (20) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
  endtask

  initial begin
    int d0, r0, n;

    vecs[0] = '{8'hED, 1'b1, -1, 10'h3ED, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, -1, 10'h3FF, 1'b1};
    vecs[2] = '{8'hA5, 1'b1,  3, 10'h3A5, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, -1, 10'h33C, 1'b0};
    vecs[4] = '{8'h01, 1'b0, -1, 10'h201, 1'b1};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_err", tx_err, 1'b0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // tx_valid while busy must be dropped, not queued.
    d0 = done_cnt;
    r0 = req_cnt;
    send_byte(8'hF4);
    fork
      dev_receive(1'b1, -1, -1, cap, seen);
      begin
        repeat (400) @(negedge clk);
        chk("busy_ready_low", tx_ready, 1'b0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    chk("busy_frame", cap, 10'h2F4);
    wait_done(d0 + 1);
    chk("busy_err", done_err, 1'b0);
    repeat (300) @(negedge clk);
    chk("busy_one_done", done_cnt - d0, 1);
    chk("busy_one_req", req_cnt - r0, 1);

    // Device never clocks: watchdog measured from clock release.
    send_byte(8'h12);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < INH + RQ + 50);
    chk("tmo_release_seen", (ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1), 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < TMO + 100);
    chk("timeout_cycles", n, TMO);
    chk("timeout_err", tx_err, 1'b1);
    chk("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("timeout_ready", tx_ready, 1'b1);
    repeat (20) @(negedge clk);

    // Reset in the middle of the data bits.
    d0 = done_cnt;
    send_byte(8'h96);
    dev_receive(1'b1, -1, 5, cap, seen);
    chk("rstmid_started", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_clk_oe", ps2_clk_oe, 1'b0);
    chk("rstmid_data_oe", ps2_data_oe, 1'b0);
    chk("rstmid_ready", tx_ready, 1'b1);
    chk("rstmid_busy", tx_busy, 1'b0);
    chk("rstmid_done", tx_done, 1'b0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("rstmid_no_done", done_cnt - d0, 0);
    run_vec('{8'h00, 1'b1, -1, 10'h300, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte per request to the keyboard (e.g. 0xFF reset, 0xED LED set, 0xF4 enable).
- It is the reverse direction of the existing PS/2 keyboard receive path and runs alongside it on the same ps2_clk/ps2_data lines.
- Lines are open-collector: this block only asserts "drive low" enables. Tristate buffers live in top.
- tx_busy lets the receive path ignore frames while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles ps2_clk is held low before the request (120 us at 100 MHz).
- REQ_CYCLES, 200: clk cycles both lines are held low before the clock is released (2 us).
- TIMEOUT_CYCLES, 2000000: frame watchdog, measured from clock release to line idle (20 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples needed to change the filtered ps2_clk level.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset
- ps2_clk_in  in  1  raw PS/2 clock line level
- ps2_data_in  in  1  raw PS/2 data line level
- tx_data  in  8  command byte
- tx_valid  in  1  request strobe
- tx_ready  out  1  block idle, can accept a byte
- tx_busy  out  1  transmission in progress
- ps2_clk_oe  out  1  1 = pull ps2_clk low
- ps2_data_oe  out  1  1 = pull ps2_data low
- tx_done  out  1  one-cycle completion pulse
- tx_err  out  1  qualifies tx_done: 1 = no ACK or timeout

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values: tx_ready=1, tx_busy=0, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0. State is IDLE and all counters are 0.
- Reset asserted mid-frame releases both lines on the next clk edge and returns to IDLE. No done pulse is generated.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass a 2-FF synchronizer.
  - ps2_clk is filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - fall = one-cycle pulse when the filtered clock goes 1->0.
- Handshake:
  - A byte is accepted when tx_valid && tx_ready. tx_data is latched that cycle.
  - tx_ready drops and tx_busy rises the following cycle.
  - tx_valid while not ready is ignored, not queued.
- Shift frame: 11 bits = start 0, D0..D7 (LSB first), odd parity (~^tx_data), stop 1. The host also samples the device ACK.
- State machine:
  - IDLE: lines released. Accept -> INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
  - REQ: clk_oe=1, data_oe=1 (start bit) for REQ_CYCLES cycles -> SEND. On leaving, clk_oe=0, bit index=0, watchdog starts.
  - SEND: on each fall, data_oe <= ~bit.
    - Falls 1-8 drive D0..D7.
    - Fall 9 drives parity.
    - Fall 10 sets data_oe=0 (stop bit released) -> ACK.
  - ACK: on the next fall, sample the synchronized data. 0 = ACK ok, 1 = NACK. -> WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and synced data=1 -> IDLE. tx_done pulses in the IDLE entry cycle, with tx_err=NACK. tx_ready returns 1 the same cycle.
- Watchdog:
  - Counts from SEND entry. It does not restart per bit.
  - Reaching TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE releases both lines and goes to IDLE, with tx_done=1 and tx_err=1.
- Device traffic:
  - The inhibit phase aborts any device frame in progress; this is legal PS/2 behaviour.
  - Falls seen during INHIBIT or REQ are ignored.
- Glitches on ps2_clk shorter than FILTER_LEN cycles must not advance the bit index.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- With the macro defined:
  - A NACK or timeout re-enters INHIBIT with the same latched byte.
  - Up to 2 retries; the retry count is cleared on accept.
  - tx_done/tx_err pulse only after success or the final failed attempt.
  - tx_busy stays 1 throughout.
- Without the macro: a single attempt; failure is reported immediately.

Decomposition:
- Shared package/header ps2_pkg:
  - state encodings (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - frame-length constant 11;
  - default timing constants;
  - odd-parity function.
  - The receive path reuses the same package.
- One sub-module: ps2_line_filter. It covers the 2-FF sync, FILTER_LEN debounce and fall pulse, and is shared with the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing.
  - Required: data bits 1,0,1,1,0,1,1,1 (LSB first), then parity 1 and stop 1 are sampled on the rising edges.
  - tx_done=1, tx_err=0; the INHIBIT low time is exactly 12000 cycles.
- Send 0xFF with the device never ACKing (data stays 1 at fall 11).
  - Required: tx_done=1, tx_err=1; lines released.
  - With PS2_TX_RETRY_EN defined: 3 full frames are seen before the single tx_done.
- Device never clocks after REQ.
  - Required: exactly 2000000 cycles after clock release, tx_done=1, tx_err=1, both oe=0.
- tx_valid pulsed while busy with 0x55.
  - Required: ignored; only the original byte 0xF4 is transmitted; one tx_done.
- Inject a 3-cycle low glitch on ps2_clk mid-byte.
  - Required: no extra bit; byte 0xA5 received intact by the model.
- Assert rst during SEND bit 4.
  - Required: next cycle ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, no tx_done; a subsequent 0x00 send completes with parity bit 1.
